flash_audio_sequencer: RTL and testbench
========================================

# flash_audio_sequencer

Sequences flash reads for the keyboard-controlled audio player. It consumes the play/stop, direction and restart controls from the keyboard FSM plus an audio-rate tick. It issues Avalon-style reads of 32-bit song words, splits each word into two 16-bit samples, and presents one 8-bit sample per tick to the audio output path.

## Interface
- `LAST_ADDR`, default 23'h7FFFF: final word address of the song.
- `clk  in  1`: system clock.
- `reset  in  1`: synchronous, active-high reset.
- `sample_tick  in  1`: one-`clk` pulse at the audio sample rate, already synchronised to `clk`.
- `play_stop  in  1`: 1 = play, 0 = pause.
- `forward_backward  in  1`: 1 = forward, 0 = backward.
- `restart  in  1`: pulse that rewinds to the start of the song for the current direction.
- `flash_read  out  1`: read request; held until accepted.
- `flash_address  out  23`: word address; stable while `flash_read` = 1.
- `flash_waitrequest  in  1`: request not accepted this cycle.
- `flash_readdata  in  32`: read word.
- `flash_readdatavalid  in  1`: `flash_readdata` valid this cycle.
- `audio_data  out  8`: current sample, bits [15:8] of the selected 16-bit half.
- `audio_valid  out  1`: one-cycle pulse marking a new `audio_data`.
- `state  out  3`: FSM state, for debug. Encoding: IDLE=0, READ=1, WAIT_DATA=2, HOLD=3, ENDED=4.

## Operation
- Reset values:
  - Outputs: `flash_read`=0, `flash_address`=0, `audio_data`=0, `audio_valid`=0, `state`=IDLE.
  - Internal: `restart_pending`=0.
- IDLE:
  - On `sample_tick` with `play_stop`=1, latch `forward_backward` into `dir_q` and go to READ.
  - A tick with `play_stop`=0 is dropped.
- READ:
  - `flash_read`=1 and `flash_address`=addr.
  - Leave for WAIT_DATA on the first cycle with `flash_waitrequest`=0.
  - Never drop a request early, including on pause or restart.
- WAIT_DATA, on the cycle `flash_readdatavalid`=1:
  - Capture the word.
  - Emit the first sample: `dir_q`=1 selects [15:0], `dir_q`=0 selects [31:16].
  - Go to HOLD.
- HOLD:
  - Wait for `sample_tick` with `play_stop`=1; ticks while paused are dropped.
  - On an accepted tick, emit the other half of the word and advance addr: +1 if `dir_q`=1, −1 otherwise.
  - Then go to IDLE.
- End of song:
  - Forward crosses `LAST_ADDR`, or backward crosses 0. Behaviour is set in Configuration.
- `restart`:
  - Always sets `restart_pending`. The restart applies at the first point where it is safe:
    - In IDLE or HOLD, apply it immediately.
    - In READ, hold it pending.
    - In WAIT_DATA, apply it on `readdatavalid`: discard the word, no `audio_valid`.
  - Applying a restart sets addr to 0 if `forward_backward`=1, else `LAST_ADDR`, clears `restart_pending` and goes to IDLE.
- Priority on simultaneous events: reset > restart > tick. A restart and a tick in the same cycle drop the tick.
- Direction changes take effect at the next READ. The word in HOLD keeps its `dir_q` ordering.

## Timing
- `sample_tick` in IDLE at cycle n gives `flash_read`=1 at n+1.
- With `flash_waitrequest`=0 at n+1, the state is WAIT_DATA at n+2.
- `flash_readdatavalid` at cycle m gives `audio_data`/`audio_valid` at m+1.
- Accepted tick in HOLD at cycle k gives `audio_data`/`audio_valid` at k+1 and the new addr at k+1.
- `audio_data` holds its value between pulses.
- Accepted ticks yield exactly one sample each. Requirement: tick spacing ≥ flash read latency + 3 cycles.

## Configuration
- `AUDIO_SEQ_LOOP_EN` defined:
  - The address wraps: `LAST_ADDR`+1 → 0 forward, 0−1 → `LAST_ADDR` backward.
  - Playback continues.
- `AUDIO_SEQ_LOOP_EN` undefined:
  - After emitting the second sample of the final word, go to ENDED and leave addr at the end word.
  - ENDED ignores ticks and issues no reads.
  - Only `restart` or `reset` leaves ENDED; `restart` goes to IDLE at the start address for the current direction.

## Test plan
- Reset → all outputs 0, `state`=0. Forward play with tick at addr 0, `readdata`=32'hAABB_CCDD → `audio_data`=8'hCC, then on the next tick 8'hAA, and addr becomes 1.
- Backward play at addr 5 with the same word → `audio_data` 8'hAA then 8'hCC, and addr becomes 4.
- `flash_waitrequest` high for 3 cycles with `play_stop` dropped mid-READ → `flash_read` and `flash_address` stay stable; the first sample is still emitted; ticks in HOLD are ignored until `play_stop`=1.
- `restart` pulsed in WAIT_DATA while forward from addr 0x100 → no `audio_valid`, IDLE, next read at addr 0. Same test in backward → next read at `LAST_ADDR`.
- Forward at `LAST_ADDR`, 2 ticks:
  - With `AUDIO_SEQ_LOOP_EN` → next read at addr 0.
  - Without it → `state`=4, further ticks produce no `flash_read`, and `restart` returns to IDLE.
- `restart` and `sample_tick` in the same cycle in IDLE → no `flash_read` next cycle; addr equals the start address.

Source files
------------

// File: rtl/flash_audio_sequencer_if.sv
// Avalon-style read bus between the audio sequencer (master) and the flash controller (slave).
interface flash_audio_sequencer_if;
    logic        flash_read;
    logic [22:0] flash_address;
    logic        flash_waitrequest;
    logic [31:0] flash_readdata;
    logic        flash_readdatavalid;

    modport master (
        output flash_read,
        output flash_address,
        input  flash_waitrequest,
        input  flash_readdata,
        input  flash_readdatavalid
    );

    modport slave (
        input  flash_read,
        input  flash_address,
        output flash_waitrequest,
        output flash_readdata,
        output flash_readdatavalid
    );
endinterface

// File: rtl/flash_audio_sequencer.sv
// Reads 32-bit song words from flash and plays them as two 8-bit samples per word, one per tick.
// Optional AUDIO_SEQ_LOOP_EN: wrap the address at either end of the song instead of stopping in ENDED.
module flash_audio_sequencer #(
    parameter logic [22:0] LAST_ADDR = 23'h7FFFF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           sample_tick,
    input  logic                           play_stop,
    input  logic                           forward_backward,
    input  logic                           restart,
    flash_audio_sequencer_if.master        flash,
    output logic [7:0]                     audio_data,
    output logic                           audio_valid,
    output logic [2:0]                     state
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ      = 3'd1,
        WAIT_DATA = 3'd2,
        HOLD      = 3'd3,
        ENDED     = 3'd4
    } state_t;

    state_t      r_state;
    logic [22:0] r_addr;
    logic        r_dir;
    logic        r_flash_read;
    logic        r_restart_pending;
    logic [7:0]  r_audio_data;
    logic        r_audio_valid;
    logic [7:0]  r_second;

    logic        w_tick_ok;
    logic        w_apply;
    logic [22:0] w_start;
    logic        w_final;
    logic [22:0] w_next_addr;
    logic        w_unused_low_bytes;

    assign w_tick_ok = sample_tick & play_stop;
    assign w_apply   = restart | r_restart_pending;
    assign w_start   = forward_backward ? '0 : LAST_ADDR;
    assign w_final   = r_dir ? (r_addr == LAST_ADDR) : (r_addr == '0);
    // Only the upper byte of each 16-bit half is played.
    assign w_unused_low_bytes = ^{flash.flash_readdata[23:16], flash.flash_readdata[7:0]};

    always_comb begin
        w_next_addr = r_dir ? r_addr + 23'd1 : r_addr - 23'd1;
`ifdef AUDIO_SEQ_LOOP_EN
        if (w_final) begin
            w_next_addr = r_dir ? '0 : LAST_ADDR;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state           <= IDLE;
            r_addr            <= '0;
            r_dir             <= 1'b0;
            r_flash_read      <= 1'b0;
            r_restart_pending <= 1'b0;
            r_audio_data      <= '0;
            r_audio_valid     <= 1'b0;
            r_second          <= '0;
        end else begin
            r_audio_valid <= 1'b0;
            if (restart) begin
                r_restart_pending <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_apply) begin
                        r_addr            <= w_start;
                        r_restart_pending <= 1'b0;
                    end else if (w_tick_ok) begin
                        r_dir        <= forward_backward;
                        r_flash_read <= 1'b1;
                        r_state      <= READ;
                    end
                end
                // The request is never withdrawn; a restart here waits for the data beat.
                READ: begin
                    if (!flash.flash_waitrequest) begin
                        r_flash_read <= 1'b0;
                        r_state      <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (flash.flash_readdatavalid) begin
                        if (w_apply) begin
                            r_addr            <= w_start;
                            r_restart_pending <= 1'b0;
                            r_state           <= IDLE;
                        end else begin
                            r_audio_data  <= r_dir ? flash.flash_readdata[15:8]  : flash.flash_readdata[31:24];
                            r_second      <= r_dir ? flash.flash_readdata[31:24] : flash.flash_readdata[15:8];
                            r_audio_valid <= 1'b1;
                            r_state       <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (w_apply) begin
                        r_addr            <= w_start;
                        r_restart_pending <= 1'b0;
                        r_state           <= IDLE;
                    end else if (w_tick_ok) begin
                        r_audio_data  <= r_second;
                        r_audio_valid <= 1'b1;
`ifdef AUDIO_SEQ_LOOP_EN
                        r_addr  <= w_next_addr;
                        r_state <= IDLE;
`else
                        if (w_final) begin
                            r_state <= ENDED;
                        end else begin
                            r_addr  <= w_next_addr;
                            r_state <= IDLE;
                        end
`endif
                    end
                end
                ENDED: begin
                    if (w_apply) begin
                        r_addr            <= w_start;
                        r_restart_pending <= 1'b0;
                        r_state           <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign flash.flash_read    = r_flash_read;
    assign flash.flash_address = r_addr;
    assign audio_data          = r_audio_data;
    assign audio_valid         = r_audio_valid;
    assign state               = r_state;
endmodule

// File: tb/tb_flash_audio_sequencer.sv
// Directed scoreboard bench for flash_audio_sequencer; expected samples are queued by the stimulus and popped by a monitor.
module tb_flash_audio_sequencer;
    localparam logic [22:0] LAST = 23'h103;

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_tick;
    logic       play_stop;
    logic       forward_backward;
    logic       restart;
    logic [7:0] audio_data;
    logic       audio_valid;
    logic [2:0] state;

    flash_audio_sequencer_if bus ();

    flash_audio_sequencer #(.LAST_ADDR(LAST)) dut (
        .clk              (clk),
        .reset            (reset),
        .sample_tick      (sample_tick),
        .play_stop        (play_stop),
        .forward_backward (forward_backward),
        .restart          (restart),
        .flash            (bus),
        .audio_data       (audio_data),
        .audio_valid      (audio_valid),
        .state            (state)
    );

    always #5 clk = ~clk;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every audio_valid pulse must match the oldest queued sample.
    always @(negedge clk) begin
        if (reset === 1'b0 && audio_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_sample: got audio_data %0h with no sample expected", audio_data);
            end else begin
                chk("audio_data", 32'(audio_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected $finish");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        cyc();
        restart = 1'b0;
    endtask

    function automatic logic [15:0] order(input logic [31:0] w, input logic d);
        return d ? {w[15:8], w[31:24]} : {w[31:24], w[15:8]};
    endfunction

    function automatic logic [31:0] word_for(input int a);
        return 32'h1357_9BDF ^ (32'(a) * 32'h0101_0101);
    endfunction

    // One full word from IDLE: tick, accepted read, data beat, second tick.
    task automatic play_word(input logic [31:0] w, input logic [22:0] a, input logic [7:0] s1, input logic [7:0] s2);
        play_stop   = 1'b1;
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        chk("read_req", 32'(bus.flash_read), 32'd1);
        chk("read_addr", 32'(bus.flash_address), 32'(a));
        cyc();
        chk("wait_state", 32'(state), 32'd2);
        exp_q.push_back(s1);
        bus.flash_readdata      = w;
        bus.flash_readdatavalid = 1'b1;
        cyc();
        bus.flash_readdatavalid = 1'b0;
        chk("hold_state", 32'(state), 32'd3);
        exp_q.push_back(s2);
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        cyc();
    endtask

    task automatic restart_in_wait(input logic [22:0] start);
        play_stop   = 1'b1;
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        cyc();
        chk("rw_wait_state", 32'(state), 32'd2);
        pulse_restart();
        cyc();
        bus.flash_readdata      = 32'hAABB_CCDD;
        bus.flash_readdatavalid = 1'b1;
        cyc();
        bus.flash_readdatavalid = 1'b0;
        chk("rw_idle", 32'(state), 32'd0);
        chk("rw_addr", 32'(bus.flash_address), 32'(start));
        chk("rw_no_read", 32'(bus.flash_read), 32'd0);
        cyc();
    endtask

    initial begin
        logic [31:0] w;
        logic [15:0] o;
        reset                   = 1'b1;
        sample_tick             = 1'b0;
        play_stop               = 1'b0;
        forward_backward        = 1'b1;
        restart                 = 1'b0;
        bus.flash_waitrequest   = 1'b0;
        bus.flash_readdata      = '0;
        bus.flash_readdatavalid = 1'b0;
        repeat (3) cyc();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_read", 32'(bus.flash_read), 32'd0);
        chk("rst_addr", 32'(bus.flash_address), 32'd0);
        chk("rst_data", 32'(audio_data), 32'd0);
        chk("rst_valid", 32'(audio_valid), 32'd0);
        reset = 1'b0;
        cyc();

        play_word(32'hAABB_CCDD, 23'd0, 8'hCC, 8'hAA);
        chk("fwd_addr", 32'(bus.flash_address), 32'd1);
        chk("fwd_idle", 32'(state), 32'd0);
        for (int a = 1; a < 'h100; a++) begin
            w = word_for(a);
            o = order(w, 1'b1);
            play_word(w, 23'(a), o[15:8], o[7:0]);
        end
        chk("fwd_addr_100", 32'(bus.flash_address), 32'h100);

        restart_in_wait(23'd0);
        w = word_for(0);
        o = order(w, 1'b1);
        play_word(w, 23'd0, o[15:8], o[7:0]);

        forward_backward = 1'b0;
        pulse_restart();
        chk("bwd_start", 32'(bus.flash_address), 32'(LAST));
        for (int a = int'(LAST); a > 5; a--) begin
            w = word_for(a);
            o = order(w, 1'b0);
            play_word(w, 23'(a), o[15:8], o[7:0]);
        end
        play_word(32'hAABB_CCDD, 23'd5, 8'hAA, 8'hCC);
        chk("bwd_addr", 32'(bus.flash_address), 32'd4);

        restart_in_wait(LAST);
        w = word_for(7);
        o = order(w, 1'b0);
        play_word(w, LAST, o[15:8], o[7:0]);

        forward_backward = 1'b1;
        pulse_restart();
        chk("wr_start", 32'(bus.flash_address), 32'd0);
        bus.flash_waitrequest = 1'b1;
        play_stop             = 1'b1;
        sample_tick           = 1'b1;
        cyc();
        sample_tick = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("wr_read_held", 32'(bus.flash_read), 32'd1);
            chk("wr_addr_stable", 32'(bus.flash_address), 32'd0);
            chk("wr_read_state", 32'(state), 32'd1);
            if (i == 1) play_stop = 1'b0;
            cyc();
        end
        bus.flash_waitrequest = 1'b0;
        chk("wr_read_still", 32'(bus.flash_read), 32'd1);
        cyc();
        chk("wr_wait_state", 32'(state), 32'd2);
        chk("wr_read_drop", 32'(bus.flash_read), 32'd0);
        exp_q.push_back(8'hCC);
        bus.flash_readdata      = 32'hAABB_CCDD;
        bus.flash_readdatavalid = 1'b1;
        cyc();
        bus.flash_readdatavalid = 1'b0;
        chk("wr_hold", 32'(state), 32'd3);
        for (int i = 0; i < 2; i++) begin
            sample_tick = 1'b1;
            cyc();
            sample_tick = 1'b0;
            cyc();
            chk("paused_hold", 32'(state), 32'd3);
        end
        play_stop = 1'b1;
        exp_q.push_back(8'hAA);
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        chk("resume_idle", 32'(state), 32'd0);
        chk("resume_addr", 32'(bus.flash_address), 32'd1);
        cyc();

        forward_backward = 1'b0;
        pulse_restart();
        chk("end_start", 32'(bus.flash_address), 32'(LAST));
        forward_backward = 1'b1;
        play_word(32'h1122_3344, LAST, 8'h33, 8'h11);
`ifdef AUDIO_SEQ_LOOP_EN
        chk("loop_idle", 32'(state), 32'd0);
        chk("loop_addr", 32'(bus.flash_address), 32'd0);
        w = word_for(9);
        o = order(w, 1'b1);
        play_word(w, 23'd0, o[15:8], o[7:0]);
`else
        chk("ended_state", 32'(state), 32'd4);
        chk("ended_addr", 32'(bus.flash_address), 32'(LAST));
        for (int i = 0; i < 2; i++) begin
            sample_tick = 1'b1;
            cyc();
            sample_tick = 1'b0;
            chk("ended_no_read", 32'(bus.flash_read), 32'd0);
            cyc();
            chk("ended_stays", 32'(state), 32'd4);
        end
        pulse_restart();
        chk("ended_restart_idle", 32'(state), 32'd0);
        chk("ended_restart_addr", 32'(bus.flash_address), 32'd0);
`endif

        forward_backward = 1'b0;
        play_stop        = 1'b1;
        restart          = 1'b1;
        sample_tick      = 1'b1;
        cyc();
        restart     = 1'b0;
        sample_tick = 1'b0;
        chk("rt_no_read", 32'(bus.flash_read), 32'd0);
        chk("rt_idle", 32'(state), 32'd0);
        chk("rt_addr", 32'(bus.flash_address), 32'(LAST));
        cyc();
        chk("rt_no_read2", 32'(bus.flash_read), 32'd0);

        repeat (3) cyc();
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
